// File: rtl/gshare_branch_tracker.sv
// In-order tracker for gshare predictions: logs each issued prediction, emits one
// registered training beat per resolved branch, and flushes + stalls fetch on a mispredict.
module gshare_branch_tracker #(
   parameter int PC_W   = 7,
   parameter int HIST_W = 7,
   parameter int DEPTH  = 8
) (
   input  logic                       clk,
   input  logic                       areset_n,
   input  logic                       fetch_valid,
   input  logic [PC_W-1:0]            fetch_pc,
   output logic                       fetch_ready,
   output logic                       fetch_pred_taken,
   output logic                       predict_valid,
   output logic [PC_W-1:0]            predict_pc,
   input  logic                       predict_taken,
   input  logic [HIST_W-1:0]          predict_history,
   input  logic                       resolve_valid,
   input  logic                       resolve_taken,
   output logic                       resolve_ready,
   output logic                       train_valid,
   output logic [PC_W-1:0]            train_pc,
   output logic [HIST_W-1:0]          train_history,
   output logic                       train_taken,
   output logic                       train_mispredicted,
   output logic [$clog2(DEPTH):0]     occupancy,
   output logic [15:0]                mispredict_count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = PC_W + HIST_W + 1;

   typedef enum logic {NORMAL, RECOVER} state_t;

   logic [ENT_W-1:0]  mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   state_t            state_q, state_d;
   logic              train_valid_q, train_valid_d;
   logic [PC_W-1:0]   train_pc_q, train_pc_d;
   logic [HIST_W-1:0] train_hist_q, train_hist_d;
   logic              train_taken_q, train_taken_d;
   logic              train_mis_q, train_mis_d;
   logic [15:0]       mis_cnt_q, mis_cnt_d;

   logic              enq, deq, mis;
   logic [ENT_W-1:0]  head;

   assign fetch_ready      = (state_q == NORMAL) && (count_q < CNT_W'(DEPTH));
   assign resolve_ready    = (count_q != '0);
   assign predict_valid    = fetch_valid && fetch_ready;
   assign predict_pc       = fetch_pc;
   assign fetch_pred_taken = predict_taken;

   assign enq  = predict_valid;
   assign deq  = resolve_valid && resolve_ready;
   assign head = mem[rd_ptr_q];
   assign mis  = deq && (resolve_taken ^ head[0]);

   // Entry layout: {pc, history, predicted direction}. Flushed writes are simply orphaned.
   always_ff @(posedge clk) begin
      if (enq) mem[wr_ptr_q] <= {fetch_pc, predict_history, predict_taken};
   end

   always_comb begin
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      state_d       = NORMAL;
      mis_cnt_d     = mis_cnt_q;
      train_valid_d = deq;
      train_pc_d    = train_pc_q;
      train_hist_d  = train_hist_q;
      train_taken_d = train_taken_q;
      train_mis_d   = train_mis_q;
      if (deq) begin
         train_pc_d    = head[ENT_W-1 -: PC_W];
         train_hist_d  = head[HIST_W:1];
         train_taken_d = resolve_taken;
         train_mis_d   = mis;
      end
      if (mis) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         state_d  = RECOVER;
         if (mis_cnt_q != 16'hFFFF) mis_cnt_d = mis_cnt_q + 16'd1;
      end else begin
         if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
      end
   end

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         state_q       <= NORMAL;
         mis_cnt_q     <= '0;
         train_valid_q <= 1'b0;
         train_pc_q    <= '0;
         train_hist_q  <= '0;
         train_taken_q <= 1'b0;
         train_mis_q   <= 1'b0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         state_q       <= state_d;
         mis_cnt_q     <= mis_cnt_d;
         train_valid_q <= train_valid_d;
         train_pc_q    <= train_pc_d;
         train_hist_q  <= train_hist_d;
         train_taken_q <= train_taken_d;
         train_mis_q   <= train_mis_d;
      end
   end

   assign train_valid        = train_valid_q;
   assign train_pc           = train_pc_q;
   assign train_history      = train_hist_q;
   assign train_taken        = train_taken_q;
   assign train_mispredicted = train_mis_q;
   assign occupancy          = count_q;
   assign mispredict_count   = mis_cnt_q;
endmodule
